// File: rtl/ananke_sr_arb.sv
// Round-robin arbiter sharing the single system-register access port among NUM_REQ requesters.
// One access in flight at a time; a bounded timeout aborts an access that is never acknowledged.
module ananke_sr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  nwarmreset,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    dest_i,
  input  logic [NUM_REQ*7-1:0]  addr_i,
  input  logic [NUM_REQ-1:0]    write_i,
  input  logic [NUM_REQ*64-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic                  err_o,
  output logic [63:0]           rdata_o,
  output logic                  sr_req_o,
  input  logic                  sr_ack_i,
  output logic                  sr_dest_o,
  output logic [6:0]            sr_addr_o,
  output logic                  sr_write_o,
  output logic [63:0]           sr_wdata_o,
  input  logic [63:0]           sr_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   win_q, win_d;
  logic              dest_q, dest_d;
  logic [6:0]        addr_q, addr_d;
  logic              write_q, write_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Round-robin search starting at the priority pointer.
  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   cand_idx;
  int unsigned       cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IdxW'(cand);
      if (!pick_valid && req_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  logic              pick_dest;
  logic [6:0]        pick_addr;
  logic              pick_write;
  logic [63:0]       pick_wdata;

  always_comb begin
    pick_dest  = 1'b0;
    pick_addr  = '0;
    pick_write = 1'b0;
    pick_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (IdxW'(k) == pick_idx) begin
        pick_dest  = dest_i[k];
        pick_addr  = addr_i[7*k +: 7];
        pick_write = write_i[k];
        pick_wdata = wdata_i[64*k +: 64];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    dest_d  = dest_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          win_d   = pick_idx;
          dest_d  = pick_dest;
          addr_d  = pick_addr;
          write_d = pick_write;
          wdata_d = pick_wdata;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // An ack in the final counted cycle takes precedence over the timeout.
        if (sr_ack_i) begin
          rdata_d = sr_rdata_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        ptr_d   = (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nwarmreset) begin
    if (!nwarmreset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      dest_q  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      dest_q  <= dest_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign sr_req_o   = (state_q == StIssue);
  assign busy_o     = (state_q != StIdle);
  assign sr_dest_o  = dest_q;
  assign sr_addr_o  = addr_q;
  assign sr_write_o = write_q;
  assign sr_wdata_o = wdata_q;

  always_comb begin
    ack_o   = '0;
    err_o   = 1'b0;
    rdata_o = '0;
    if (state_q == StResp) begin
      ack_o[win_q] = 1'b1;
      err_o        = err_q;
      rdata_o      = rdata_q;
    end
  end

endmodule

// File: tb/tb_ananke_sr_arb.sv
// Scoreboard bench for ananke_sr_arb: stimulus pushes expected completions, a negedge
// monitor pops and compares them whenever ack_o pulses.
module tb_ananke_sr_arb;

  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           nwarmreset;
  logic [NR-1:0]    req_i, dest_i, write_i;
  logic [NR*7-1:0]  addr_i;
  logic [NR*64-1:0] wdata_i;
  logic [NR-1:0]    ack_o;
  logic             err_o;
  logic [63:0]      rdata_o;
  logic             sr_req_o, sr_ack_i, sr_dest_o, sr_write_o, busy_o;
  logic [6:0]       sr_addr_o;
  logic [63:0]      sr_wdata_o, sr_rdata_i;

  ananke_sr_arb #(
    .NUM_REQ(NR),
    .TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .nwarmreset(nwarmreset),
    .req_i     (req_i),
    .dest_i    (dest_i),
    .addr_i    (addr_i),
    .write_i   (write_i),
    .wdata_i   (wdata_i),
    .ack_o     (ack_o),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .sr_req_o  (sr_req_o),
    .sr_ack_i  (sr_ack_i),
    .sr_dest_o (sr_dest_o),
    .sr_addr_o (sr_addr_o),
    .sr_write_o(sr_write_o),
    .sr_wdata_o(sr_wdata_o),
    .sr_rdata_i(sr_rdata_i),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_payload(input int k, input logic [6:0] a, input logic wr, input logic d,
                             input logic [63:0] wd);
    addr_i[7*k +: 7]   = a;
    write_i[k]         = wr;
    dest_i[k]          = d;
    wdata_i[64*k +: 64] = wd;
  endtask

  task automatic push(input int idx, input logic err, input logic [63:0] rd);
    exp_t e;
    e.idx   = idx;
    e.err   = err;
    e.rdata = rd;
    sb_q.push_back(e);
  endtask

  // Monitor: every ack_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nwarmreset) begin
      if (ack_o != '0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack_o=%b with nothing outstanding", ack_o);
        end else begin
          mon_e = sb_q.pop_front();
          check("ack_o", 64'(ack_o), 64'(4'b0001 << mon_e.idx));
          check("err_o", 64'(err_o), 64'(mon_e.err));
          check("rdata_o", rdata_o, mon_e.rdata);
        end
      end else begin
        check("idle_err_o", 64'(err_o), 64'd0);
        check("idle_rdata_o", rdata_o, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_idx;
    nwarmreset = 1'b0;
    req_i      = '0;
    dest_i     = '0;
    write_i    = '0;
    addr_i     = '0;
    wdata_i    = '0;
    sr_ack_i   = 1'b0;
    sr_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sr_req", 64'(sr_req_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_payload", {sr_wdata_o[55:0], sr_addr_o, sr_write_o},
          64'd0 | 64'(sr_dest_o));
    nwarmreset = 1'b1;
    tick();

    // Round-robin with all four requesting continuously.
    for (int k = 0; k < NR; k++) set_payload(k, 7'h10 + 7'(k), 1'b0, 1'b0, 64'd0);
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (!sr_req_o && n < 8) begin
        tick();
        n++;
      end
      check("rr_issue_seen", 64'(sr_req_o), 64'd1);
      exp_idx = g % NR;
      check("rr_grant_addr", 64'(sr_addr_o), 64'(7'h10 + 7'(exp_idx)));
      push(exp_idx, 1'b0, 64'h100 + 64'(exp_idx));
      sr_ack_i   = 1'b1;
      sr_rdata_i = 64'h100 + 64'(exp_idx);
      tick();
      sr_ack_i = 1'b0;
      if (g == 4) req_i = '0;
      tick();
      check("rr_gap_sr_req", 64'(sr_req_o), 64'd0);
    end
    tick();

    // Single read by requester 2, minimum latency.
    set_payload(2, 7'h15, 1'b0, 1'b0, 64'd0);
    req_i = 4'b0100;
    push(2, 1'b0, 64'hDEAD_BEEF_0123_4567);
    tick();
    check("rd_sr_req_cycle1", 64'(sr_req_o), 64'd1);
    check("rd_sr_addr", 64'(sr_addr_o), 64'h15);
    check("rd_sr_write", 64'(sr_write_o), 64'd0);
    sr_ack_i   = 1'b1;
    sr_rdata_i = 64'hDEAD_BEEF_0123_4567;
    tick();
    sr_ack_i = 1'b0;
    check("rd_ack_cycle2", 64'(ack_o), 64'b0100);
    req_i = '0;
    tick();
    check("rd_idle_after", 64'(busy_o), 64'd0);
    tick();

    // Timeout: bus never acknowledges.
    set_payload(3, 7'h2A, 1'b0, 1'b0, 64'd0);
    sr_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
    req_i = 4'b1000;
    push(3, 1'b1, 64'd0);
    tick();
    n = 0;
    while (sr_req_o && n < 20) begin
      n++;
      tick();
    end
    check("to_sr_req_cycles", 64'(n), 64'd4);
    check("to_ack", 64'(ack_o), 64'b1000);
    req_i = '0;
    tick();
    tick();
    sr_ack_i = 1'b1;
    tick();
    sr_ack_i = 1'b0;
    check("to_stray_sr_req", 64'(sr_req_o), 64'd0);
    check("to_stray_busy", 64'(busy_o), 64'd0);
    tick();
    check("to_stray_ack", 64'(ack_o), 64'd0);
    tick();

    // Ack in the last ISSUE cycle wins over the timeout.
    set_payload(0, 7'h01, 1'b0, 1'b0, 64'd0);
    req_i = 4'b0001;
    tick();
    repeat (3) tick();
    check("bd_still_issuing", 64'(sr_req_o), 64'd1);
    sr_ack_i   = 1'b1;
    sr_rdata_i = 64'hA5A5_5A5A_0F0F_F0F0;
    push(0, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0);
    tick();
    sr_ack_i = 1'b0;
    req_i = '0;
    tick();
    tick();

    // Write by requester 1 with dest = 1; payload must hold until the ack.
    set_payload(1, 7'h03, 1'b1, 1'b1, 64'h1);
    req_i = 4'b0010;
    tick();
    for (int c = 0; c < 3; c++) begin
      check("wr_sr_write", 64'(sr_write_o), 64'd1);
      check("wr_sr_dest", 64'(sr_dest_o), 64'd1);
      check("wr_sr_wdata", sr_wdata_o, 64'h1);
      check("wr_sr_addr", 64'(sr_addr_o), 64'h3);
      if (c < 2) tick();
    end
    sr_ack_i   = 1'b1;
    sr_rdata_i = 64'h77;
    push(1, 1'b0, 64'h77);
    tick();
    sr_ack_i = 1'b0;
    req_i = '0;
    tick();
    tick();

    // Reset in the 2nd ISSUE cycle; pointer would otherwise favour requester 2.
    for (int k = 0; k < NR; k++) set_payload(k, 7'h40 + 7'(k), 1'b0, 1'b0, 64'd0);
    req_i = 4'b1111;
    tick();
    check("rs_pre_grant_addr", 64'(sr_addr_o), 64'h42);
    tick();
    #2;
    nwarmreset = 1'b0;
    #1;
    check("rs_async_sr_req", 64'(sr_req_o), 64'd0);
    check("rs_async_busy", 64'(busy_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rs_no_ack", 64'(ack_o), 64'd0);
    nwarmreset = 1'b1;
    tick();
    check("rs_reissue", 64'(sr_req_o), 64'd1);
    check("rs_first_grant_addr", 64'(sr_addr_o), 64'h40);
    sr_ack_i   = 1'b1;
    sr_rdata_i = 64'hC0DE;
    push(0, 1'b0, 64'hC0DE);
    tick();
    sr_ack_i = 1'b0;
    req_i = '0;
    repeat (3) tick();

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
